// File: rtl/div_seq_if.sv
// div_seq_if: request/response bundle for the sequential divider.
//
// Handshake rule for both directions: a transfer happens on a rising clock
// edge where valid and ready are both high. The sender holds valid and its
// payload steady until that edge. The receiver may raise or lower ready
// freely.
//   Request : i_valid / o_ready, payload i_dividend, i_divisor
//   Response: o_valid / i_ready, payload o_quotient, o_remainder,
//             o_div_by_zero
//
// The signal names follow the divider's point of view: i_* enters the
// divider and o_* leaves it.
//   slave  modport: used by the divider.
//   master modport: used by the requester/consumer.
interface div_seq_if #(
  parameter int N = 64
);
  logic         i_valid;
  logic         o_ready;
  logic [N-1:0] i_dividend;
  logic [N-1:0] i_divisor;
  logic         o_valid;
  logic         i_ready;
  logic [N-1:0] o_quotient;
  logic [N-1:0] o_remainder;
  logic         o_div_by_zero;

  modport slave (
    input  i_valid, i_dividend, i_divisor, i_ready,
    output o_ready, o_valid, o_quotient, o_remainder, o_div_by_zero
  );

  modport master (
    output i_valid, i_dividend, i_divisor, i_ready,
    input  o_ready, o_valid, o_quotient, o_remainder, o_div_by_zero
  );
endinterface

// File: rtl/div_seq.sv
// div_seq: iterative unsigned restoring divider. It performs one
// subtract-and-shift step per cycle and produces N quotient bits in N cycles.
//
// Ports:
//   i_clk    clock. All state changes on the rising edge.
//   i_rst_n  synchronous active-low reset.
//   bus      div_seq_if.slave. It carries the request handshake
//            (i_valid/o_ready, i_dividend, i_divisor) and the response
//            handshake (o_valid/i_ready, o_quotient, o_remainder,
//            o_div_by_zero).
//   o_state  debug view of the FSM state: 0 IDLE, 1 RUN, 2 DONE.
//
// Optional feature macro: DIV_ZERO_FAST_EN.
//   Defined: a zero divisor skips RUN. DONE is entered one cycle after the
//            accept with the divide-by-zero result forced.
//   Undefined: a zero divisor runs all N steps. The algorithm produces the
//              same result by itself.
module div_seq #(
  parameter int N = 64
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  div_seq_if.slave   bus,
  output logic [1:0] o_state
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N:0]    rem_q, rem_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  div_q, div_d;
  logic          dbz_q, dbz_d;

  logic          accept;
  logic          divisor_zero;
  logic [N:0]    step_t;
  logic [N:0]    step_d;

  assign accept       = bus.i_valid && (state_q == S_IDLE);
  assign divisor_zero = (bus.i_divisor == '0);

  // Partial remainder shifted left by one, with the next dividend bit
  // brought in. The trial subtraction uses the same a + ~b + 1 form as the
  // ALU subtract. Bit N of the difference is set when t < divisor, which
  // means the step restores.
  assign step_t = {rem_q[N-1:0], quo_q[N-1]};
  assign step_d = step_t + ~{1'b0, div_q} + {{N{1'b0}}, 1'b1};

  // ---------------- FSM: state register ----------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
`ifdef DIV_ZERO_FAST_EN
          state_d = divisor_zero ? S_DONE : S_RUN;
`else
          state_d = S_RUN;
`endif
        end
      end
      S_RUN:   if (cnt_q == LAST_STEP) state_d = S_DONE;
      S_DONE:  if (bus.i_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs (pure state decodes) ----------------
  always_comb begin
    bus.o_ready = (state_q == S_IDLE);
    bus.o_valid = (state_q == S_DONE);
    o_state     = state_q;
  end

  // ---------------- datapath next state ----------------
  always_comb begin
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    div_d = div_q;
    dbz_d = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d = '0;
          div_d = bus.i_divisor;
          dbz_d = divisor_zero;
          rem_d = '0;
          quo_d = bus.i_dividend;
`ifdef DIV_ZERO_FAST_EN
          if (divisor_zero) begin
            quo_d = '1;
            rem_d = {1'b0, bus.i_dividend};
          end
`endif
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (!step_d[N]) begin
          rem_d = step_d;
          quo_d = {quo_q[N-2:0], 1'b1};
        end else begin
          rem_d = step_t;
          quo_d = {quo_q[N-2:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      div_q <= div_d;
      dbz_q <= dbz_d;
    end
  end

  assign bus.o_quotient    = quo_q;
  assign bus.o_remainder   = rem_q[N-1:0];
  assign bus.o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

  logic       clk;
  logic       rst_n;
  logic [1:0] state8;
  logic [1:0] state64;

  div_seq_if #(.N(8))  bus8 ();
  div_seq_if #(.N(64)) bus64 ();

  div_seq #(.N(8)) dut8 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus8.slave),
    .o_state (state8)
  );

  div_seq #(.N(64)) dut64 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus64.slave),
    .o_state (state64)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZERO_LAT8 = 1;
`else
  localparam int ZERO_LAT8 = 9;
`endif

  // Each scoreboard entry packs {quotient, remainder, div_by_zero}.
  logic [128:0] exp_q[$];

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic dut_ready(input bit w);
    return w ? bus64.o_ready : bus8.o_ready;
  endfunction

  function automatic logic dut_valid(input bit w);
    return w ? bus64.o_valid : bus8.o_valid;
  endfunction

  function automatic logic [63:0] dut_quo(input bit w);
    return w ? bus64.o_quotient : {56'd0, bus8.o_quotient};
  endfunction

  function automatic logic [63:0] dut_rem(input bit w);
    return w ? bus64.o_remainder : {56'd0, bus8.o_remainder};
  endfunction

  function automatic logic dut_dbz(input bit w);
    return w ? bus64.o_div_by_zero : bus8.o_div_by_zero;
  endfunction

  // Reference behaviour written straight from the arithmetic definition.
  function automatic logic [128:0] model(input bit w, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask;
    logic [63:0] q;
    logic [63:0] r;
    mask = w ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_0000_00FF;
    if ((b & mask) == 64'd0) begin
      q = mask;
      r = a & mask;
    end else begin
      q = (a & mask) / (b & mask);
      r = (a & mask) % (b & mask);
    end
    return {q, r, ((b & mask) == 64'd0)};
  endfunction

  // ---------------- driver tasks (entered and left on a negedge) ----------------
  task automatic drive_req(input bit w, input logic v, input logic [63:0] a, input logic [63:0] b);
    if (w) begin
      bus64.i_valid = v; bus64.i_dividend = a; bus64.i_divisor = b;
    end else begin
      bus8.i_valid = v; bus8.i_dividend = a[7:0]; bus8.i_divisor = b[7:0];
    end
  endtask

  task automatic drive_rdy(input bit w, input logic r);
    if (w) bus64.i_ready = r;
    else   bus8.i_ready = r;
  endtask

  // Present one request, let it be accepted, then drop i_valid.
  task automatic send(input bit w, input logic [63:0] a, input logic [63:0] b, input bit push);
    check("req_ready_before_accept", {63'd0, dut_ready(w)}, 64'd1);
    drive_req(w, 1'b1, a, b);
    if (push) exp_q.push_back(model(w, a, b));
    @(posedge clk);
    @(negedge clk);
    drive_req(w, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 64'hDEAD_BEEF_DEAD_BEEF);
  endtask

  // Called at the first negedge after the accept edge (cycle k+1).
  task automatic wait_valid(input bit w, input int exp_lat);
    int lat;
    lat = 1;
    while (!dut_valid(w) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("resp_valid_seen", {63'd0, dut_valid(w)}, 64'd1);
    check("resp_latency", 64'(lat), 64'(exp_lat));
  endtask

  // Compare the response against the scoreboard, then complete the handshake.
  task automatic take(input bit w);
    logic [128:0] e;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: observed 0 entries expected at least 1");
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("quotient", dut_quo(w), e[128:65]);
    check("remainder", dut_rem(w), e[64:1]);
    check("div_by_zero", {63'd0, dut_dbz(w)}, {63'd0, e[0]});
    drive_rdy(w, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive_rdy(w, 1'b0);
    check("idle_ready_after_resp", {63'd0, dut_ready(w)}, 64'd1);
    check("valid_low_after_resp", {63'd0, dut_valid(w)}, 64'd0);
  endtask

  task automatic check_reset_outputs(input bit w);
    check("rst_ready", {63'd0, dut_ready(w)}, 64'd1);
    check("rst_valid", {63'd0, dut_valid(w)}, 64'd0);
    check("rst_quotient", dut_quo(w), 64'd0);
    check("rst_remainder", dut_rem(w), 64'd0);
    check("rst_dbz", {63'd0, dut_dbz(w)}, 64'd0);
    check("rst_state", w ? {62'd0, state64} : {62'd0, state8}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int rises;
    rst_n = 1'b0;
    drive_req(1'b0, 1'b0, 64'd0, 64'd0);
    drive_req(1'b1, 1'b0, 64'd0, 64'd0);
    drive_rdy(1'b0, 1'b0);
    drive_rdy(1'b1, 1'b0);

    // Reset held for two edges.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs(1'b0);
    check_reset_outputs(1'b1);

    // N=8 basic case: 200/7 with the consumer ready.
    drive_rdy(1'b0, 1'b1);
    send(1'b0, 64'd200, 64'd7, 1'b1);
    drive_rdy(1'b0, 1'b0);
    wait_valid(1'b0, 9);
    take(1'b0);

    // N=64 edge values.
    send(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    wait_valid(1'b1, 65);
    take(1'b1);
    send(1'b1, 64'd5, 64'd9, 1'b1);
    wait_valid(1'b1, 65);
    take(1'b1);
    send(1'b1, 64'd9, 64'd9, 1'b1);
    wait_valid(1'b1, 65);
    take(1'b1);
    send(1'b1, 64'hFEDC_BA98_7654_3210, 64'h0000_0001_2345_6789, 1'b1);
    wait_valid(1'b1, 65);
    take(1'b1);

    // Divide by zero on N=8.
    send(1'b0, 64'd77, 64'd0, 1'b1);
    wait_valid(1'b0, ZERO_LAT8);
    take(1'b0);

    // A few random N=8 operands, including divisor 1 and equal operands.
    for (int i = 0; i < 6; i++) begin
      logic [63:0] a;
      logic [63:0] b;
      a = 64'($urandom_range(0, 255));
      b = (i == 0) ? 64'd1 : (i == 1) ? a : 64'($urandom_range(1, 255));
      send(1'b0, a, b, 1'b1);
      wait_valid(1'b0, 9);
      take(1'b0);
    end

    // Backpressure: DONE held for five cycles while a new request waits.
    send(1'b0, 64'd150, 64'd11, 1'b1);
    wait_valid(1'b0, 9);
    drive_req(1'b0, 1'b1, 64'd99, 64'd5);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_valid_held", {63'd0, bus8.o_valid}, 64'd1);
      check("bp_no_accept", {63'd0, bus8.o_ready}, 64'd0);
      check("bp_quotient_stable", {56'd0, bus8.o_quotient}, 64'd13);
      check("bp_remainder_stable", {56'd0, bus8.o_remainder}, 64'd7);
    end
    take(1'b0);
    // The waiting request is taken at the edge ending this IDLE cycle.
    exp_q.push_back(model(1'b0, 64'd99, 64'd5));
    @(posedge clk);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 64'd0, 64'd0);
    check("bp_second_accepted", {63'd0, bus8.o_ready}, 64'd0);
    wait_valid(1'b0, 9);
    take(1'b0);

    // Reset in the 4th RUN cycle aborts the operation.
    send(1'b0, 64'd200, 64'd7, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("abort_in_run", {62'd0, state8}, 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs(1'b0);
    rises = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus8.o_valid) rises++;
    end
    check("abort_no_result", 64'(rises), 64'd0);
    send(1'b0, 64'd100, 64'd3, 1'b1);
    wait_valid(1'b0, 9);
    take(1'b0);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
